// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the uDLX pipeline hazard sequencer: FSM state encodings,
// default register address width and the stall/flush control bundle.
package pipeline_pkg;

    localparam int REG_ADDR_WIDTH_DEF = 5;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_ABORT    = 2'b10
    } state_e;

    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic if_id_flush;
        logic id_ex_stall;
        logic id_ex_flush;
        logic ex_mem_stall;
        logic ex_mem_flush;
        logic mem_wb_flush;
        logic mem_err;
    } ctrl_t;

    // Bit order follows ctrl_t: pc, if_id s/f, id_ex s/f, ex_mem s/f, mem_wb f, err
    localparam ctrl_t CTRL_NONE      = ctrl_t'(9'b000000000);
    localparam ctrl_t CTRL_MEM_STALL = ctrl_t'(9'b110101010);
    localparam ctrl_t CTRL_BRANCH    = ctrl_t'(9'b001010100);
    localparam ctrl_t CTRL_LOAD_USE  = ctrl_t'(9'b110010000);
    localparam ctrl_t CTRL_ABORT     = ctrl_t'(9'b000000011);

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side control bundle of the hazard sequencer: hazard/memory/branch status
// from the datapath and stall/flush commands back to the pipeline registers.
interface pipeline_hazard_ctrl_if
    import pipeline_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
    parameter int CNT_WIDTH      = 16
);
    logic [REG_ADDR_WIDTH-1:0] id_rs_addr_in;
    logic [REG_ADDR_WIDTH-1:0] id_rt_addr_in;
    logic                      id_rs_used_in;
    logic                      id_rt_used_in;
    logic                      ex_load_in;
    logic [REG_ADDR_WIDTH-1:0] ex_wr_addr_in;
    logic                      mem_req_in;
    logic                      mem_ack_in;
    logic                      branch_taken_in;
    logic                      stall_cnt_clr_in;
    logic                      pc_stall_out;
    logic                      if_id_stall_out;
    logic                      if_id_flush_out;
    logic                      id_ex_stall_out;
    logic                      id_ex_flush_out;
    logic                      ex_mem_stall_out;
    logic                      ex_mem_flush_out;
    logic                      mem_wb_flush_out;
    logic                      mem_err_out;
    logic [CNT_WIDTH-1:0]      stall_count_out;
    logic [1:0]                state_out;

    modport master (
        output id_rs_addr_in, id_rt_addr_in, id_rs_used_in, id_rt_used_in,
               ex_load_in, ex_wr_addr_in, mem_req_in, mem_ack_in,
               branch_taken_in, stall_cnt_clr_in,
        input  pc_stall_out, if_id_stall_out, if_id_flush_out, id_ex_stall_out,
               id_ex_flush_out, ex_mem_stall_out, ex_mem_flush_out,
               mem_wb_flush_out, mem_err_out, stall_count_out, state_out
    );

    modport slave (
        input  id_rs_addr_in, id_rt_addr_in, id_rs_used_in, id_rt_used_in,
               ex_load_in, ex_wr_addr_in, mem_req_in, mem_ack_in,
               branch_taken_in, stall_cnt_clr_in,
        output pc_stall_out, if_id_stall_out, if_id_flush_out, id_ex_stall_out,
               id_ex_flush_out, ex_mem_stall_out, ex_mem_flush_out,
               mem_wb_flush_out, mem_err_out, stall_count_out, state_out
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational load-use compare between the load in EX and the sources read in ID.
// Register 0 is hard-wired, so a load targeting it never creates a hazard.
module hazard_detect #(
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  ex_load_in,
    input  logic [ADDR_WIDTH-1:0] ex_wr_addr_in,
    input  logic [ADDR_WIDTH-1:0] rs_addr_in,
    input  logic                  rs_used_in,
    input  logic [ADDR_WIDTH-1:0] rt_addr_in,
    input  logic                  rt_used_in,
    output logic                  hazard_out
);

    // Match either used source against the load destination
    always_comb begin
        hazard_out = 1'b0;
        if (ex_load_in && (ex_wr_addr_in != {ADDR_WIDTH{1'b0}})) begin
            hazard_out = (rs_used_in && (rs_addr_in == ex_wr_addr_in)) ||
                         (rt_used_in && (rt_addr_in == ex_wr_addr_in));
        end else begin
            hazard_out = 1'b0;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the uDLX 5-stage pipeline: memory wait states with a
// timeout watchdog, taken-branch flushes and load-use stalls, plus a stall-cycle counter.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
    parameter int MEM_TIMEOUT    = 16,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipeline_hazard_ctrl_if.slave bus
);

    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    state_e                state_r;
    state_e                state_nxt_s;
    logic [WAIT_W-1:0]     wait_cnt_r;
    logic [WAIT_W-1:0]     wait_cnt_nxt_s;
    logic [WAIT_W-1:0]     wait_cnt_inc_s;
    logic [CNT_WIDTH-1:0]  stall_cnt_r;
    logic                  load_use_s;
    logic                  mem_stall_s;
    ctrl_t                 ctrl_dec_s;
    ctrl_t                 ctrl_out_s;

    hazard_detect #(
        .ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_hazard_detect (
        .ex_load_in    (bus.ex_load_in),
        .ex_wr_addr_in (bus.ex_wr_addr_in),
        .rs_addr_in    (bus.id_rs_addr_in),
        .rs_used_in    (bus.id_rs_used_in),
        .rt_addr_in    (bus.id_rt_addr_in),
        .rt_used_in    (bus.id_rt_used_in),
        .hazard_out    (load_use_s)
    );

    assign mem_stall_s    = bus.mem_req_in && !bus.mem_ack_in;
    assign wait_cnt_inc_s = wait_cnt_r + WAIT_ONE;

    // Next-state and control decode; memory stall outranks branch, branch outranks load-use
    always_comb begin
        state_nxt_s    = state_r;
        wait_cnt_nxt_s = wait_cnt_r;
        ctrl_dec_s     = CTRL_NONE;
        case (state_r)
            ST_RUN: begin
                if (mem_stall_s) begin
                    ctrl_dec_s     = CTRL_MEM_STALL;
                    wait_cnt_nxt_s = WAIT_ONE;
                    state_nxt_s    = (WAIT_ONE == WAIT_LAST) ? ST_ABORT : ST_MEM_WAIT;
                end else if (bus.branch_taken_in) begin
                    ctrl_dec_s = CTRL_BRANCH;
                end else if (load_use_s) begin
                    ctrl_dec_s = CTRL_LOAD_USE;
                end else begin
                    ctrl_dec_s = CTRL_NONE;
                end
            end
            ST_MEM_WAIT: begin
                if (bus.mem_ack_in) begin
                    ctrl_dec_s     = CTRL_NONE;
                    wait_cnt_nxt_s = {WAIT_W{1'b0}};
                    state_nxt_s    = ST_RUN;
                end else begin
                    ctrl_dec_s     = CTRL_MEM_STALL;
                    wait_cnt_nxt_s = wait_cnt_inc_s;
                    state_nxt_s    = (wait_cnt_inc_s == WAIT_LAST) ? ST_ABORT : ST_MEM_WAIT;
                end
            end
            ST_ABORT: begin
                // Pipeline advances, but the faulted access must not write back
                ctrl_dec_s     = CTRL_ABORT;
                wait_cnt_nxt_s = {WAIT_W{1'b0}};
                state_nxt_s    = ST_RUN;
            end
            default: begin
                ctrl_dec_s     = CTRL_NONE;
                wait_cnt_nxt_s = {WAIT_W{1'b0}};
                state_nxt_s    = ST_RUN;
            end
        endcase
    end

    // Force every control output quiet while reset is held
    always_comb begin
        ctrl_out_s = CTRL_NONE;
        if (!rst_n) begin
            ctrl_out_s = CTRL_NONE;
        end else begin
            ctrl_out_s = ctrl_dec_s;
        end
    end

    // FSM state and watchdog counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_RUN;
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
        end
    end

    // Saturating stall-cycle counter; clear beats increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (bus.stall_cnt_clr_in) begin
            stall_cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (ctrl_out_s.pc_stall && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign bus.pc_stall_out     = ctrl_out_s.pc_stall;
    assign bus.if_id_stall_out  = ctrl_out_s.if_id_stall;
    assign bus.if_id_flush_out  = ctrl_out_s.if_id_flush;
    assign bus.id_ex_stall_out  = ctrl_out_s.id_ex_stall;
    assign bus.id_ex_flush_out  = ctrl_out_s.id_ex_flush;
    assign bus.ex_mem_stall_out = ctrl_out_s.ex_mem_stall;
    assign bus.ex_mem_flush_out = ctrl_out_s.ex_mem_flush;
    assign bus.mem_wb_flush_out = ctrl_out_s.mem_wb_flush;
    assign bus.mem_err_out      = ctrl_out_s.mem_err;
    assign bus.stall_count_out  = stall_cnt_r;
    assign bus.state_out        = state_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed cycles push hand-computed
// expectations; a negedge monitor pops and compares each one against the DUT.
module tb_pipeline_hazard_ctrl;

    // Expected control vector order: pc, if_id s/f, id_ex s/f, ex_mem s/f, mem_wb f, err
    localparam logic [8:0] E_NONE = 9'b000000000;
    localparam logic [8:0] E_MEM  = 9'b110101010;
    localparam logic [8:0] E_BR   = 9'b001010100;
    localparam logic [8:0] E_LU   = 9'b110010000;
    localparam logic [8:0] E_AB   = 9'b000000011;

    typedef struct packed {
        logic [8:0] ctrl;
        logic [1:0] st;
        logic [3:0] cnt;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total_cnt;
    int   pass_cnt;
    exp_t exp_q[$];
    string name_q[$];

    pipeline_hazard_ctrl_if #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(4)) bus ();

    pipeline_hazard_ctrl #(
        .REG_ADDR_WIDTH (5),
        .MEM_TIMEOUT    (16),
        .CNT_WIDTH      (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive(input logic ld, input logic [4:0] wr, input logic [4:0] rs,
                         input logic rsu, input logic [4:0] rt, input logic rtu,
                         input logic req, input logic ack, input logic br, input logic clr);
        bus.ex_load_in       = ld;
        bus.ex_wr_addr_in    = wr;
        bus.id_rs_addr_in    = rs;
        bus.id_rs_used_in    = rsu;
        bus.id_rt_addr_in    = rt;
        bus.id_rt_used_in    = rtu;
        bus.mem_req_in       = req;
        bus.mem_ack_in       = ack;
        bus.branch_taken_in  = br;
        bus.stall_cnt_clr_in = clr;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Queue the expectation for the current cycle, then move to just after the next edge
    task automatic expect_cycle(input string nm, input logic [8:0] c,
                                input logic [1:0] s, input logic [3:0] n);
        exp_t e;
        e.ctrl = c;
        e.st   = s;
        e.cnt  = n;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    // Monitor: the DUT presents a fresh control decode every cycle
    initial begin
        exp_t  e;
        string nm;
        logic [8:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                act = {bus.pc_stall_out, bus.if_id_stall_out, bus.if_id_flush_out,
                       bus.id_ex_stall_out, bus.id_ex_flush_out, bus.ex_mem_stall_out,
                       bus.ex_mem_flush_out, bus.mem_wb_flush_out, bus.mem_err_out};
                total_cnt++;
                if (act === e.ctrl && bus.state_out === e.st && bus.stall_count_out === e.cnt) begin
                    pass_cnt++;
                end else begin
                    $display("FAIL %s: got ctrl=%b state=%0d cnt=%0d, want ctrl=%b state=%0d cnt=%0d",
                             nm, act, bus.state_out, bus.stall_count_out, e.ctrl, e.st, e.cnt);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total_cnt = 0;
        pass_cnt  = 0;
        rst_n     = 1'b0;
        idle();
        @(posedge clk);
        #1;
        expect_cycle("reset", E_NONE, 2'd0, 4'd0);
        rst_n = 1'b1;
        expect_cycle("idle", E_NONE, 2'd0, 4'd0);

        // Load-use on rs, then on rt, then non-hazards
        drive(1'b1, 5'd5, 5'd5, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_cycle("lu_rs", E_LU, 2'd0, 4'd0);
        idle();
        expect_cycle("lu_rs_release", E_NONE, 2'd0, 4'd1);
        drive(1'b1, 5'd7, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_cycle("lu_rt", E_LU, 2'd0, 4'd1);
        idle();
        expect_cycle("lu_rt_release", E_NONE, 2'd0, 4'd2);
        drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_cycle("lu_r0", E_NONE, 2'd0, 4'd2);
        drive(1'b1, 5'd9, 5'd9, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_cycle("lu_unused", E_NONE, 2'd0, 4'd2);
        drive(1'b0, 5'd9, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_cycle("lu_noload", E_NONE, 2'd0, 4'd2);
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_cycle("clr_assert", E_NONE, 2'd0, 4'd2);
        idle();
        expect_cycle("clr_done", E_NONE, 2'd0, 4'd0);

        // Memory access acknowledged on the fourth cycle
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_cycle("mem_w0", E_MEM, 2'd0, 4'd0);
        expect_cycle("mem_w1", E_MEM, 2'd1, 4'd1);
        expect_cycle("mem_w2", E_MEM, 2'd1, 4'd2);
        bus.mem_ack_in = 1'b1;
        expect_cycle("mem_ack", E_NONE, 2'd1, 4'd3);
        idle();
        expect_cycle("mem_after", E_NONE, 2'd0, 4'd3);
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_cycle("mem_zero_wait", E_NONE, 2'd0, 4'd3);

        // Branch beats a simultaneous load-use hazard
        drive(1'b1, 5'd4, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_cycle("br_lu", E_BR, 2'd0, 4'd3);
        idle();
        expect_cycle("br_after", E_NONE, 2'd0, 4'd3);

        // Branch ignored while the memory stall is active
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        expect_cycle("br_mem_run", E_MEM, 2'd0, 4'd3);
        expect_cycle("br_mem_wait", E_MEM, 2'd1, 4'd4);
        drive(1'b1, 5'd6, 5'd6, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        expect_cycle("br_lu_mem_wait", E_MEM, 2'd1, 4'd5);
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_cycle("br_mem_ack", E_NONE, 2'd1, 4'd6);
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_cycle("clr2_assert", E_NONE, 2'd0, 4'd6);
        idle();
        expect_cycle("clr2_done", E_NONE, 2'd0, 4'd0);

        // Access never acknowledged: 15 stall cycles, then one ABORT cycle
        bus.mem_req_in = 1'b1;
        expect_cycle("to_run", E_MEM, 2'd0, 4'd0);
        for (int k = 1; k <= 14; k++) begin
            expect_cycle($sformatf("to_wait%0d", k), E_MEM, 2'd1, 4'(k));
        end
        bus.mem_ack_in = 1'b1;
        expect_cycle("to_abort", E_AB, 2'd2, 4'd15);
        idle();
        expect_cycle("to_after", E_NONE, 2'd0, 4'd15);

        // Saturation, then clear at the saturated value and clear beating increment
        drive(1'b1, 5'd8, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_cycle("sat_lu", E_LU, 2'd0, 4'd15);
        idle();
        expect_cycle("sat_hold", E_NONE, 2'd0, 4'd15);
        bus.stall_cnt_clr_in = 1'b1;
        expect_cycle("sat_clr", E_NONE, 2'd0, 4'd15);
        drive(1'b1, 5'd8, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_cycle("clr_vs_inc", E_LU, 2'd0, 4'd0);
        idle();
        expect_cycle("clr_vs_inc_after", E_NONE, 2'd0, 4'd0);

        // Reset asserted during the fourth memory-wait cycle
        bus.mem_req_in = 1'b1;
        expect_cycle("rst_mem0", E_MEM, 2'd0, 4'd0);
        expect_cycle("rst_mem1", E_MEM, 2'd1, 4'd1);
        expect_cycle("rst_mem2", E_MEM, 2'd1, 4'd2);
        expect_cycle("rst_mem3", E_MEM, 2'd1, 4'd3);
        rst_n = 1'b0;
        expect_cycle("rst_mid_wait", E_NONE, 2'd0, 4'd0);
        expect_cycle("rst_hold", E_NONE, 2'd0, 4'd0);
        rst_n = 1'b1;
        idle();
        expect_cycle("rst_release", E_NONE, 2'd0, 4'd0);
        expect_cycle("rst_quiet", E_NONE, 2'd0, 4'd0);

        repeat (3) @(posedge clk);
        total_cnt++;
        if (exp_q.size() == 0) begin
            pass_cnt++;
        end else begin
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
